sprite_rom_arbiter: RTL

- Shares one single-port, read-only sprite ROM among NUM_REQ pixel requesters, for example several on-screen instances of the same sprite in the game renderer.
- Each cycle it grants one requester in round-robin order and converts the (x,y) sprite coordinate to a linear ROM address.
- It drives the ROM address, then returns the read word tagged with the requester ID at a fixed latency.
- It sits between the per-object draw logic and the sprite ROM instance. That ROM has 1600 x 16-bit words, an unregistered output and 1-cycle read latency.

---
 rtl/sprite_rom_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM among NUM_REQ pixel requesters.
// Converts (x,y) to a linear address and returns the ROM word tagged with the requester id.
module sprite_rom_arbiter #(
  parameter int unsigned       NUM_REQ     = 3,
  parameter int unsigned       SPR_W       = 40,
  parameter int unsigned       SPR_H       = 40,
  parameter int unsigned       COORD_W     = 6,
  parameter int unsigned       ADDR_W      = 11,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [DATA_W-1:0] TRANSPARENT = '0
) (
  input  logic                       clka,
  input  logic                       rsta,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_W-1:0]          rom_dout,
  output logic                       rd_valid,
  output logic [1:0]                 rd_id,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int unsigned ID_W  = 2;
  localparam int unsigned LIN_W = 32;

  logic [COORD_W-1:0] xs [NUM_REQ];
  logic [COORD_W-1:0] ys [NUM_REQ];

  logic [ID_W-1:0]    ptr;
  logic               any_req_c;
  logic [ID_W-1:0]    win_c;
  logic [ID_W-1:0]    ptr_nxt_c;
  logic [NUM_REQ-1:0] gnt_c;
  logic [COORD_W-1:0] win_x_c;
  logic [COORD_W-1:0] win_y_c;
  logic               oob_c;
  logic [LIN_W-1:0]   lin_c;

  logic               s0_valid;
  logic [ID_W-1:0]    s0_id;
  logic               s0_oob;
  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  logic               s1_oob;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign xs[i] = req_x[i*COORD_W +: COORD_W];
    assign ys[i] = req_y[i*COORD_W +: COORD_W];
  end

  // First pending requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W-1:0] idx;
    any_req_c = 1'b0;
    win_c     = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((LIN_W'(ptr) + k) % NUM_REQ);
      if (!any_req_c && req[idx]) begin
        any_req_c = 1'b1;
        win_c     = idx;
      end
    end
  end

  // Winner decode, pointer advance and coordinate-to-address conversion.
  always_comb begin
    gnt_c     = NUM_REQ'(1) << win_c;
    ptr_nxt_c = (win_c == ID_W'(NUM_REQ - 1)) ? '0 : win_c + ID_W'(1);
    win_x_c   = xs[win_c];
    win_y_c   = ys[win_c];
    oob_c     = (LIN_W'(win_x_c) >= SPR_W) || (LIN_W'(win_y_c) >= SPR_H);
    lin_c     = LIN_W'(win_y_c) * SPR_W + LIN_W'(win_x_c);
  end

  // Stage 0: grant, pointer update, address issue; an out-of-bounds read keeps the old address.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      gnt      <= '0;
      ptr      <= '0;
      rom_addr <= '0;
      s0_valid <= 1'b0;
      s0_id    <= '0;
      s0_oob   <= 1'b0;
    end else begin
      gnt      <= '0;
      s0_valid <= 1'b0;
      if (en && any_req_c) begin
        gnt      <= gnt_c;
        ptr      <= ptr_nxt_c;
        s0_valid <= 1'b1;
        s0_id    <= win_c;
        s0_oob   <= oob_c;
        if (!oob_c) begin
          rom_addr <= ADDR_W'(lin_c);
        end
      end
    end
  end

  // Stage 1: ROM samples rom_addr; transaction tag follows it.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_oob   <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      s1_id    <= s0_id;
      s1_oob   <= s0_oob;
    end
  end

  // Stage 2: capture ROM output, substituting the transparent colour when out of bounds.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_valid;
      if (s1_valid) begin
        rd_id   <= s1_id;
        rd_data <= s1_oob ? TRANSPARENT : rom_dout;
      end
    end
  end

endmodule
